program_load_sequencer: RTL
===========================

// Module: program_load_sequencer
// PURPOSE
//  Owns the 15-bit control word and the 8-bit bus during program load.
//  In RUN it passes control_block's word through unchanged.
//  In LOAD it holds the CPU, accepts bytes over a valid/ready handshake, and sequences
//  the MAR and RAM to write them to consecutive 16-byte RAM addresses 0..15.
//  It then releases the CPU. Sits between control_block and the datapath control fan-out.
// PARAMETERS
//  ADDR_W   4      RAM address width; depth = 2**ADDR_W
//  DATA_W   8      bus/data width
//  CW_W     15     control word width (bit map in cpu_ctrl_pkg)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous reset, active-high
//  load_req     in   1       request program load (level, sampled in IDLE/RUN)
//  run_req      in   1       start CPU from IDLE
//  load_end     in   1       finish load early (sampled in WAIT only)
//  byte_valid   in   1       byte_in valid
//  byte_in      in   DATA_W  program byte
//  byte_ready   out  1       high only in WAIT; transfer = byte_valid & byte_ready
//  cpu_cw_in    in   CW_W    control word from control_block
//  cw_out       out  CW_W    control word to datapath
//  bus_drive_en out  1       loader drives bus (ext tri-state enable)
//  bus_data     out  DATA_W  value driven when bus_drive_en
//  cpu_run      out  1       1 = CPU released (gates control_block resetn externally)
//  load_done    out  1       one-cycle pulse on DONE
//  load_count   out  ADDR_W+1 bytes written in last/current load (0..16)
// BEHAVIOUR
//  Reset: state=IDLE, cw_out=IDLE_CW (15'h0FE3: all active-low strobes high,
//   all active-high strobes low), cpu_run=0, byte_ready=0, bus_drive_en=0,
//   bus_data=0, load_done=0, load_count=0, addr_ctr=0. Every output is registered.
//   Reset mid-load aborts immediately; RAM contents are not restored.
//  States: IDLE, RUN, WAIT, ADDR, DATA, WRITE, DONE.
//  IDLE: load_req -> WAIT (priority over run_req); run_req -> RUN.
//  RUN: cpu_run=1, cw_out=cpu_cw_in (1-cycle registered).
//   load_req -> WAIT; cpu_run drops the next cycle.
//  WAIT: entry from IDLE/RUN clears addr_ctr and load_count. byte_ready=1, cw_out=IDLE_CW.
//   Transfer -> latch byte, go ADDR. Else load_end -> DONE.
//   Simultaneous transfer + load_end: byte wins; load_end is ignored.
//  ADDR (1 cyc): bus_drive_en=1, bus_data={0,addr_ctr}, nLma=0.
//  DATA (1 cyc): bus_drive_en=1, bus_data=latched byte, nLmd=0.
//  WRITE (1 cyc): nCE=0, nLr=1 (RAM write); addr_ctr++, load_count++.
//   After the write at addr 15 (addr_ctr wraps to 0) -> DONE; otherwise -> WAIT.
//  Per-byte latency: transfer to end of WRITE = 3 cycles; next byte_ready on 4th.
//  DONE (1 cyc): load_done=1 -> RUN (cpu_run=1 the following cycle).
//  In WAIT..DONE, cw_out=IDLE_CW except the single strobe listed above.
//   cpu_cw_in is ignored there.
//  load_req/run_req ignored outside IDLE/RUN. byte_valid outside WAIT is not consumed.
//  bus_drive_en is never 1 in RUN/IDLE, so there is no bus contention with CPU drivers.
// STRUCTURE
//  cpu_ctrl_pkg: CW bit indices (CP=14 ... NLO=0), IDLE_CW, state enum.
//  Shared with control_block.
//  Single module; no sub-module (FSM + addr counter + output regs).
// TESTING
//  1. Reset, run_req=1 -> RUN; cpu_cw_in=15'h5A5A appears on cw_out one cycle later; cpu_run=1.
//  2. load_req, send 3 bytes 8'h1E,8'h2F,8'hE0, then load_end.
//     Per byte, one cycle each in order:
//      ADDR: nLma low, bus_data=addr 0,1,2
//      DATA: nLmd low, bus_data=byte
//      WRITE: nCE low
//     Then load_done pulse, load_count=3, cpu_run=1 two cycles after load_end.
//  3. 16 back-to-back bytes, byte_valid held high -> addresses 0..15.
//     byte_ready every 4th cycle. Auto DONE after addr 15; load_count=16; no load_end needed.
//  4. byte_valid and load_end both high in WAIT -> byte written, then WAIT again.
//     Second load_end -> DONE.
//  5. rst asserted during DATA of byte 2 -> all outputs at reset values asynchronously.
//     No nCE pulse occurs; state IDLE.
//  6. load_req during RUN -> cpu_run=0 next cycle, addr restarts at 0.
//     Bus driven only in ADDR/DATA.

Source files
------------

// File: rtl/program_load_sequencer_pkg.sv
// program_load_sequencer_pkg: control word bit map, idle word and loader state encoding
package program_load_sequencer_pkg;
  localparam int CW_W = 15;
  localparam int CP   = 14;
  localparam int EP   = 13;
  localparam int HLT  = 12;
  localparam int NLMA = 11;
  localparam int NLMD = 10;
  localparam int NCE  = 9;
  localparam int NLR  = 8;
  localparam int NLI  = 7;
  localparam int NEI  = 6;
  localparam int NLA  = 5;
  localparam int EA   = 4;
  localparam int SU   = 3;
  localparam int EU   = 2;
  localparam int NLB  = 1;
  localparam int NLO  = 0;
  localparam logic [CW_W-1:0] IDLE_CW = 15'h0FE3;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_ADDR, S_DATA, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/program_load_sequencer_if.sv
// program_load_sequencer_if: loader handshake, control word and bus signals
//   master = loader host / control_block side, slave = program_load_sequencer
interface program_load_sequencer_if
  import program_load_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              load_req;
  logic              run_req;
  logic              load_end;
  logic              byte_valid;
  logic [DATA_W-1:0] byte_in;
  logic              byte_ready;
  logic [CW_W-1:0]   cpu_cw_in;
  logic [CW_W-1:0]   cw_out;
  logic              bus_drive_en;
  logic [DATA_W-1:0] bus_data;
  logic              cpu_run;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  modport master (
    output load_req, run_req, load_end, byte_valid, byte_in, cpu_cw_in,
    input  byte_ready, cw_out, bus_drive_en, bus_data, cpu_run, load_done, load_count
  );
  modport slave (
    input  load_req, run_req, load_end, byte_valid, byte_in, cpu_cw_in,
    output byte_ready, cw_out, bus_drive_en, bus_data, cpu_run, load_done, load_count
  );
endinterface

// File: rtl/program_load_sequencer.sv
// program_load_sequencer: owns control word and bus during program load, passes CPU word in RUN
//   clk, rst (async, active-high); bus: load_req/run_req/load_end requests, byte_valid/byte_in/byte_ready
//   handshake, cpu_cw_in -> cw_out, bus_drive_en/bus_data loader bus drive, cpu_run, load_done, load_count
module program_load_sequencer
  import program_load_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  program_load_sequencer_if.slave bus
);
  state_t            state, nxt;
  logic [ADDR_W-1:0] addr_ctr;
  logic [DATA_W-1:0] byte_q;
  logic [CW_W-1:0]   strobe, cw_d;
  logic              xfer;
  assign xfer = bus.byte_valid & bus.byte_ready;
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = bus.load_req ? S_WAIT : bus.run_req ? S_RUN : S_IDLE;
      S_RUN:   nxt = bus.load_req ? S_WAIT : S_RUN;
      S_WAIT:  nxt = xfer ? S_ADDR : bus.load_end ? S_DONE : S_WAIT;
      S_ADDR:  nxt = S_DATA;
      S_DATA:  nxt = S_WRITE;
      S_WRITE: nxt = &addr_ctr ? S_DONE : S_WAIT;
      S_DONE:  nxt = S_RUN;
      default: nxt = S_IDLE;
    endcase
    strobe = '0;
    strobe[NLMA] = nxt == S_ADDR;
    strobe[NLMD] = nxt == S_DATA;
    strobe[NCE] = nxt == S_WRITE;
    cw_d = nxt == S_RUN ? bus.cpu_cw_in : IDLE_CW & ~strobe;
  end
  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      addr_ctr <= '0;
      byte_q <= '0;
      bus.cw_out <= IDLE_CW;
      bus.byte_ready <= 1'b0;
      bus.bus_drive_en <= 1'b0;
      bus.bus_data <= '0;
      bus.cpu_run <= 1'b0;
      bus.load_done <= 1'b0;
      bus.load_count <= '0;
    end else begin
      state <= nxt;
      bus.cw_out <= cw_d;
      bus.byte_ready <= nxt == S_WAIT;
      bus.bus_drive_en <= nxt == S_ADDR || nxt == S_DATA;
      bus.bus_data <= nxt == S_ADDR ? DATA_W'(addr_ctr) : nxt == S_DATA ? byte_q : '0;
      bus.cpu_run <= nxt == S_RUN;
      bus.load_done <= nxt == S_DONE;
      if (xfer) byte_q <= bus.byte_in;
      if ((state == S_IDLE || state == S_RUN) && nxt == S_WAIT) begin
        addr_ctr <= '0;
        bus.load_count <= '0;
      end else if (state == S_WRITE) begin
        addr_ctr <= addr_ctr + 1'b1;
        bus.load_count <= bus.load_count + 1'b1;
      end
    end
endmodule
